// File: rtl/rob_wb_arbiter_pkg.sv
// Shared constants for the ROB writeback arbiter: data widths, requester count,
// queue depth, requester indices and the round-robin advance helper.
package rob_wb_arbiter_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int ROB_ENTRY_WIDTH = 6;

  localparam int WB_NUM_REQ     = 3;
  localparam int WB_QUEUE_DEPTH = 2;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MEM = 1;
  localparam int WB_SRC_MUL = 2;

  function automatic int wb_rr_next(input int idx, input int num_req);
    return (idx + 32'sd1) % num_req;
  endfunction

endpackage

// File: rtl/wb_req_queue.sv
// Small synchronous FIFO holding pending {rob_id, value} writebacks for one
// execution pipeline. Clear discards everything and wins over push/pop.
module wb_req_queue
  import rob_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = ROB_ENTRY_WIDTH + WORD_SIZE,
  parameter int DEPTH  = WB_QUEUE_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       push_data,
  output logic [DATA_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s && !(reset || clear)) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares the single ROB writeback port between ALU, MEM and MUL pipelines:
// per-requester queues, a round-robin pick over queue heads, registered wb bus.
module rob_wb_arbiter #(
  parameter int WORD_SIZE       = rob_wb_arbiter_pkg::WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = rob_wb_arbiter_pkg::ROB_ENTRY_WIDTH,
  parameter int NUM_REQ         = rob_wb_arbiter_pkg::WB_NUM_REQ,
  parameter int DEPTH           = rob_wb_arbiter_pkg::WB_QUEUE_DEPTH,
  parameter int SRC_W           = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*ROB_ENTRY_WIDTH-1:0] req_rob_id,
  input  logic [NUM_REQ*WORD_SIZE-1:0]       req_value,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               wb_valid,
  output logic [ROB_ENTRY_WIDTH-1:0]         wb_rob_id,
  output logic [WORD_SIZE-1:0]               wb_value,
  output logic [SRC_W-1:0]                   wb_src
);

  import rob_wb_arbiter_pkg::*;

  localparam int DATA_W = ROB_ENTRY_WIDTH + WORD_SIZE;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]  head_s  [NUM_REQ];
  logic [CNT_W-1:0]   count_s [NUM_REQ];
  logic [NUM_REQ-1:0] full_s;
  logic [NUM_REQ-1:0] empty_s;
  logic [NUM_REQ-1:0] push_s;
  logic [NUM_REQ-1:0] pop_s;
  logic               grant_valid_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [DATA_W-1:0]  grant_data_s;
  logic [SRC_W-1:0]   rr_ptr_r;
  int                 off_s;
  int                 best_off_s;

  // Flush blocks both enqueue and dequeue so nothing leaks through that edge.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_queue
    assign req_ready[i] = (count_s[i] != CNT_W'(DEPTH));
    assign push_s[i]    = req_valid[i] && !full_s[i] && !flush;
    assign pop_s[i]     = grant_valid_s && (grant_idx_s == SRC_W'(i)) && !flush;

    wb_req_queue #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (push_s[i]),
      .pop       (pop_s[i]),
      .push_data ({req_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH],
                   req_value[i*WORD_SIZE +: WORD_SIZE]}),
      .head_data (head_s[i]),
      .count     (count_s[i]),
      .full      (full_s[i]),
      .empty     (empty_s[i])
    );
  end

  // Round-robin pick: the non-empty head closest to rr_ptr going upward wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    grant_data_s  = '0;
    off_s         = 0;
    best_off_s    = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      off_s = (i + NUM_REQ - int'(rr_ptr_r)) % NUM_REQ;
      if (!empty_s[i] && (off_s < best_off_s)) begin
        best_off_s    = off_s;
        grant_valid_s = 1'b1;
        grant_idx_s   = SRC_W'(i);
        grant_data_s  = head_s[i];
      end else begin
        best_off_s    = best_off_s;
      end
    end
  end

  // Writeback register and round-robin pointer; payload holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_rob_id <= '0;
      wb_value  <= '0;
      wb_src    <= '0;
      rr_ptr_r  <= '0;
    end else if (flush) begin
      wb_valid  <= 1'b0;
      rr_ptr_r  <= '0;
    end else if (grant_valid_s) begin
      wb_valid               <= 1'b1;
      {wb_rob_id, wb_value}  <= grant_data_s;
      wb_src                 <= grant_idx_s;
      rr_ptr_r               <= SRC_W'(wb_rr_next(int'(grant_idx_s), NUM_REQ));
    end else begin
      wb_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_rob_wb_arbiter;
  import rob_wb_arbiter_pkg::*;

  localparam int RW = ROB_ENTRY_WIDTH;
  localparam int WS = WORD_SIZE;
  localparam int N  = WB_NUM_REQ;
  localparam int D  = WB_QUEUE_DEPTH;
  localparam int SW = $clog2(N);

  typedef struct { logic [RW-1:0] tag; logic [WS-1:0] val; } ent_t;
  typedef struct { int src; int tag; } obs_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*RW-1:0] req_rob_id = '0;
  logic [N*WS-1:0] req_value = '0;
  logic [N-1:0]    req_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_rob_id;
  logic [WS-1:0]   wb_value;
  logic [SW-1:0]   wb_src;

  rob_wb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_rob_id(req_rob_id), .req_value(req_value),
    .req_ready(req_ready), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
    .wb_value(wb_value), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t          mq [N][$];
  int            m_rr = 0;
  logic          m_valid = 1'b0;
  logic [RW-1:0] m_tag = '0;
  logic [WS-1:0] m_val = '0;
  int            m_src = 0;
  bit            chk_en = 1'b0;
  obs_t          obs_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: model evaluates on pre-edge inputs, commits at the edge.
  task automatic tick();
    logic   rst_v, fl_v;
    logic [N-1:0] acc;
    ent_t   in_e [N];
    ent_t   e;
    int     g;
    rst_v = reset;
    fl_v  = flush;
    g     = -1;
    for (int i = 0; i < N; i++) begin
      acc[i]     = req_valid[i] && (mq[i].size() < D);
      in_e[i].tag = req_rob_id[i*RW +: RW];
      in_e[i].val = req_value[i*WS +: WS];
    end
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    @(posedge clk);
    if (rst_v || fl_v) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0;
      m_rr    = 0;
      if (rst_v) begin
        m_tag  = '0;
        m_val  = '0;
        m_src  = 0;
        chk_en = 1'b1;
      end
    end else begin
      if (g >= 0) begin
        e       = mq[g].pop_front();
        m_valid = 1'b1;
        m_tag   = e.tag;
        m_val   = e.val;
        m_src   = g;
        m_rr    = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(in_e[i]);
    end
    #1;
  endtask

  // Per-cycle comparison against the model, and a log of observed writebacks.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() != D);
      check("wb_valid",  64'(wb_valid),  64'(m_valid));
      check("wb_rob_id", 64'(wb_rob_id), 64'(m_tag));
      check("wb_value",  64'(wb_value),  64'(m_val));
      check("wb_src",    64'(wb_src),    64'(m_src));
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (wb_valid === 1'b1) obs_q.push_back('{src: int'(wb_src), tag: int'(wb_rob_id)});
    end
  end

  task automatic drive(input int i, input int tag, input int val);
    req_valid[i]            = 1'b1;
    req_rob_id[i*RW +: RW]  = RW'(tag);
    req_value[i*WS +: WS]   = WS'(val);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_obs(input string name, input int k, input int src, input int tag);
    if (k < obs_q.size()) begin
      check({name, "_src"}, 64'(obs_q[k].src), 64'(src));
      check({name, "_tag"}, 64'(obs_q[k].tag), 64'(tag));
    end else begin
      check({name, "_count"}, 64'(obs_q.size()), 64'(k + 1));
    end
  endtask

  task automatic do_flush();
    req_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    obs_q.delete();
  endtask

  task automatic fill_all(input int base);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) drive(i, base + r*N + i, 1000 + base + r*N + i);
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    int n_acc;
    int same;
    int mul_tags [$];

    // reset and reset values
    tick(); tick();
    reset = 1'b0;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_rob_id", 64'(wb_rob_id), 64'd0);
    check("rst_wb_value", 64'(wb_value), 64'd0);
    check("rst_wb_src", 64'(wb_src), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'b111);

    // single push: writeback two cycles after presentation, one cycle wide
    drive(WB_SRC_ALU, 5, 32'h1234);
    tick();
    req_valid = '0;
    check("s1_lat1_valid", 64'(wb_valid), 64'd0);
    tick();
    check("s1_valid", 64'(wb_valid), 64'd1);
    check("s1_tag", 64'(wb_rob_id), 64'd5);
    check("s1_value", 64'(wb_value), 64'h1234);
    check("s1_src", 64'(wb_src), 64'd0);
    tick();
    check("s1_valid_off", 64'(wb_valid), 64'd0);
    check("s1_tag_hold", 64'(wb_rob_id), 64'd5);

    // contention from rr_ptr=0, then rr_ptr must be back at 0
    do_flush();
    drive(0, 1, 11); drive(1, 2, 22); drive(2, 3, 33);
    tick();
    idle(5);
    check("s2_count", 64'(obs_q.size()), 64'd3);
    check_obs("s2_g0", 0, 0, 1);
    check_obs("s2_g1", 1, 1, 2);
    check_obs("s2_g2", 2, 2, 3);
    obs_q.delete();
    drive(0, 10, 100); drive(2, 11, 110);
    tick();
    idle(4);
    check_obs("s2_rr0", 0, 0, 10);
    check_obs("s2_rr1", 1, 2, 11);

    // MUL backpressure while ALU/MEM keep winning
    do_flush();
    drive(0, 20, 1); drive(1, 21, 2); drive(2, 7, 70);
    tick();
    drive(0, 22, 3); drive(1, 23, 4); drive(2, 8, 80);
    tick();
    check("s3_full_ready", 64'(req_ready[2]), 64'd0);
    n_acc = -1;
    for (int n = 0; n < 10; n++) begin
      logic was_ready;
      drive(0, 24 + 2*n, 5); drive(1, 25 + 2*n, 6); drive(2, 9, 90);
      was_ready = req_ready[2];
      tick();
      if (was_ready) begin
        n_acc = n;
        break;
      end
    end
    check("s3_accept_wait", 64'(n_acc), 64'd2);
    idle(10);
    foreach (obs_q[k]) if (obs_q[k].src == 2) mul_tags.push_back(obs_q[k].tag);
    check("s3_mul_count", 64'(mul_tags.size()), 64'd3);
    if (mul_tags.size() == 3) begin
      check("s3_mul_0", 64'(mul_tags[0]), 64'd7);
      check("s3_mul_1", 64'(mul_tags[1]), 64'd8);
      check("s3_mul_2", 64'(mul_tags[2]), 64'd9);
    end

    // fairness: ALU and MEM push every cycle for 20 cycles
    do_flush();
    for (int n = 0; n < 20; n++) begin
      drive(0, n, n); drive(1, 32 + n, n);
      tick();
    end
    idle(6);
    check("s4_enough", 64'(obs_q.size() >= 20), 64'd1);
    check_obs("s4_first", 0, 0, 0);
    same = 0;
    for (int k = 1; k < 20 && k < obs_q.size(); k++)
      if (obs_q[k].src == obs_q[k-1].src || obs_q[k].src > 1) same++;
    check("s4_alternate", 64'(same), 64'd0);

    // flush mid-operation with a concurrent MEM push
    do_flush();
    fill_all(40);
    flush = 1'b1;
    drive(1, 4, 44);
    tick();
    flush = 1'b0;
    req_valid = '0;
    check("s5_wb_valid", 64'(wb_valid), 64'd0);
    check("s5_req_ready", 64'(req_ready), 64'b111);
    check("s5_pre_count", 64'(obs_q.size()), 64'd1);
    idle(6);
    check("s5_no_wb_after", 64'(obs_q.size()), 64'd1);

    // reset mid-operation, then grant order must start at index 0
    do_flush();
    fill_all(50);
    reset = 1'b1;
    drive(1, 4, 44);
    tick();
    reset = 1'b0;
    req_valid = '0;
    check("s6_wb_valid", 64'(wb_valid), 64'd0);
    check("s6_wb_rob_id", 64'(wb_rob_id), 64'd0);
    check("s6_wb_value", 64'(wb_value), 64'd0);
    check("s6_wb_src", 64'(wb_src), 64'd0);
    check("s6_req_ready", 64'(req_ready), 64'b111);
    obs_q.delete();
    drive(0, 60, 6); drive(1, 61, 7); drive(2, 62, 8);
    tick();
    idle(5);
    check("s6_count", 64'(obs_q.size()), 64'd3);
    check_obs("s6_g0", 0, 0, 60);
    check_obs("s6_g1", 1, 1, 61);
    check_obs("s6_g2", 2, 2, 62);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
